red_pitaya_pwm_meas: RTL

PWM duty-cycle capture block: the receiving end of the PWM output path. It samples an external PWM pin, measures high time and period over 2^NPL consecutive periods, and reports the accumulated counts with a one-cycle valid strobe. The accumulated high count uses the generator's duty encoding: 16 × integer part + popcount of the dither pattern, for NPL=4. It sits beside the PWM generators in the analog-mixed-signal register block, for loopback and self-test.

---
 rtl/red_pitaya_pwm_meas.sv | 91 +++++++++
 1 files changed

// File: rtl/red_pitaya_pwm_meas.sv
// red_pitaya_pwm_meas: measures PWM high time and period accumulated over 2^NPL periods
module red_pitaya_pwm_meas #(
    parameter int CW  = 8,
    parameter int NPL = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ena,
    input  logic            pwm_i,
    output logic [CW+NPL-1:0] meas_hi,
    output logic [CW+NPL-1:0] meas_per,
    output logic            meas_vld,
    output logic            stat_tmo
);
    localparam int W = CW + NPL;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_nx;
    logic           s1, s2, s3;
    logic           rise, start, close, done, tmo;
    logic [CW-1:0]  cnt_per, cnt_hi;
    logic [W-1:0]   acc_per, acc_hi;
    logic [NPL-1:0] pidx;

    always_comb begin
        rise     = s2 & ~s3;
        start    = state == IDLE && ena && rise;
        close    = state == RUN && ena && rise;
        done     = close && pidx == '1;
        // the closing edge beats saturation, so a full-scale period is still legal
        tmo      = state == RUN && ena && !rise && cnt_per == '1;
        state_nx = state;
        if (!ena || tmo)
            state_nx = IDLE;
        else if (start)
            state_nx = RUN;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            state    <= IDLE;
            cnt_per  <= '0;
            cnt_hi   <= '0;
            acc_per  <= '0;
            acc_hi   <= '0;
            pidx     <= '0;
            meas_hi  <= '0;
            meas_per <= '0;
            meas_vld <= 1'b0;
            stat_tmo <= 1'b0;
        end else begin
            s1       <= pwm_i;
            s2       <= s1;
            s3       <= s2;
            state    <= state_nx;
            meas_vld <= done;
            if (done) begin
                meas_per <= acc_per + {{NPL{1'b0}}, cnt_per};
                meas_hi  <= acc_hi + {{NPL{1'b0}}, cnt_hi};
            end
            if (done)
                stat_tmo <= 1'b0;
            else if (tmo)
                stat_tmo <= 1'b1;
            // the edge cycle itself is the first cycle of the new period
            if (start || close) begin
                cnt_per <= CW'(1);
                cnt_hi  <= CW'(1);
            end else if (state == RUN && state_nx == RUN) begin
                cnt_per <= cnt_per + CW'(1);
                cnt_hi  <= cnt_hi + {{(CW-1){1'b0}}, s2};
            end else begin
                cnt_per <= '0;
                cnt_hi  <= '0;
            end
            if (start || done || state_nx == IDLE) begin
                acc_per <= '0;
                acc_hi  <= '0;
                pidx    <= '0;
            end else if (close) begin
                acc_per <= acc_per + {{NPL{1'b0}}, cnt_per};
                acc_hi  <= acc_hi + {{NPL{1'b0}}, cnt_hi};
                pidx    <= pidx + NPL'(1);
            end
        end
    end
endmodule
